// File: rtl/pipeline_hold_ctrl.sv
// Pipeline hold/flush/bubble controller for a 5-stage MIPS pipeline.
// Turns hazard, redirect and memory-busy requests into per-stage controls, with a memory-wait watchdog and perf counters.
module pipeline_hold_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lu_stall,
   input  logic             branch_taken,
   input  logic             dmem_busy,
   input  logic             cnt_clr,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic             mem_wb_bubble,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic             timeout_err
);

   localparam int WC_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      ERR      = 2'b10
   } state_t;

   state_t          cur_state, nxt_state;
   logic [WC_W-1:0] wait_cnt, wait_nxt;
   logic            freeze;

   always_comb begin
      nxt_state     = cur_state;
      wait_nxt      = wait_cnt;
      freeze        = 1'b0;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_write  = 1'b1;
      mem_wb_bubble = 1'b0;

      case (cur_state)
         RUN, MEM_WAIT: begin
            if (dmem_busy) begin
               freeze = 1'b1;
               if (cur_state == RUN) begin
                  nxt_state = MEM_WAIT;
                  wait_nxt  = WC_W'(1);
               end else begin
                  wait_nxt = wait_cnt + WC_W'(1);
                  if (wait_cnt == WC_W'(TIMEOUT - 1)) nxt_state = ERR;
               end
            end else begin
               nxt_state = RUN;
               wait_nxt  = '0;
               if (branch_taken) begin
                  // Redirect squashes the ID instruction, so a load-use request there is moot.
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
               end else if (lu_stall) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
               end
            end
         end
         default: begin
            nxt_state = ERR;
            freeze    = 1'b1;
         end
      endcase

      if (freeze) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b0;
         id_ex_write   = 1'b0;
         id_ex_bubble  = 1'b0;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end

      // While reset is held every register is squashed to a NOP.
      if (!rst_n) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_write   = 1'b0;
         id_ex_bubble  = 1'b1;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state   <= RUN;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         wait_cnt  <= wait_nxt;
         if (nxt_state == ERR) timeout_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else if (cnt_clr) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
         if (if_id_flush && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Bench for pipeline_hold_ctrl: a behavioural model checked every cycle plus directed scenario checks.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_pipeline_hold_ctrl;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             lu_stall = 1'b0;
   logic             branch_taken = 1'b0;
   logic             dmem_busy = 1'b0;
   logic             cnt_clr = 1'b0;
   logic             pc_write, if_id_write, if_id_flush, id_ex_write;
   logic             id_ex_bubble, ex_mem_write, mem_wb_bubble, timeout_err;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   int errors = 0;
   int checks = 0;

   pipeline_hold_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .lu_stall(lu_stall), .branch_taken(branch_taken),
      .dmem_busy(dmem_busy), .cnt_clr(cnt_clr), .pc_write(pc_write),
      .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
      .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
      .mem_wb_bubble(mem_wb_bubble), .state(state), .stall_cycles(stall_cycles),
      .flush_events(flush_events), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: track the busy streak and error flag; outputs follow the priority rules directly.
   int   m_streak = 0;
   bit   m_err = 0;
   int   m_stall = 0;
   int   m_flush = 0;
   logic [6:0] e_ctl;   // pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, memwb_bub
   logic [1:0] e_state;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_streak = 0; m_err = 0; m_stall = 0; m_flush = 0;
      end
      if (!rst_n)                  e_ctl = 7'b0010101;
      else if (m_err || dmem_busy) e_ctl = 7'b0000001;
      else if (branch_taken)       e_ctl = 7'b1111110;
      else if (lu_stall)           e_ctl = 7'b0001110;
      else                         e_ctl = 7'b1101010;
      e_state = m_err ? 2'd2 : (m_streak > 0 ? 2'd1 : 2'd0);

      chk("pc_write",      {31'd0, pc_write},      {31'd0, e_ctl[6]});
      chk("if_id_write",   {31'd0, if_id_write},   {31'd0, e_ctl[5]});
      chk("if_id_flush",   {31'd0, if_id_flush},   {31'd0, e_ctl[4]});
      chk("id_ex_write",   {31'd0, id_ex_write},   {31'd0, e_ctl[3]});
      chk("id_ex_bubble",  {31'd0, id_ex_bubble},  {31'd0, e_ctl[2]});
      chk("ex_mem_write",  {31'd0, ex_mem_write},  {31'd0, e_ctl[1]});
      chk("mem_wb_bubble", {31'd0, mem_wb_bubble}, {31'd0, e_ctl[0]});
      chk("state",         {30'd0, state},         {30'd0, e_state});
      chk("timeout_err",   {31'd0, timeout_err},   {31'd0, m_err});
      chk("stall_cycles",  32'(stall_cycles),      32'(m_stall));
      chk("flush_events",  32'(flush_events),      32'(m_flush));

      if (rst_n) begin
         if (cnt_clr) begin
            m_stall = 0; m_flush = 0;
         end else begin
            if (!e_ctl[6] && m_stall < CMAX) m_stall++;
            if (e_ctl[4] && m_flush < CMAX) m_flush++;
         end
         if (!m_err) begin
            if (dmem_busy) begin
               m_streak++;
               if (m_streak == TIMEOUT) m_err = 1;
            end else begin
               m_streak = 0;
            end
         end
      end
   end

   task automatic apply(input logic lu, input logic br, input logic busy, input logic clr);
      lu_stall = lu; branch_taken = br; dmem_busy = busy; cnt_clr = clr;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply(0, 0, 0, 0);
      chk("rst pc_write", {31'd0, pc_write}, 32'd0);
      chk("rst if_id_flush", {31'd0, if_id_flush}, 32'd1);
      chk("rst mem_wb_bubble", {31'd0, mem_wb_bubble}, 32'd1);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      tick();
      // T1: idle after reset
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply(0, 0, 0, 0);
         chk("t1 pc_write", {31'd0, pc_write}, 32'd1);
         chk("t1 id_ex_bubble", {31'd0, id_ex_bubble}, 32'd0);
         chk("t1 state", {30'd0, state}, 32'd0);
         tick();
      end
      chk("t1 stall_cycles", 32'(stall_cycles), 32'd0);

      // T2: single load-use stall
      do_reset();
      apply(1, 0, 0, 0);
      chk("t2 pc_write", {31'd0, pc_write}, 32'd0);
      chk("t2 if_id_write", {31'd0, if_id_write}, 32'd0);
      chk("t2 id_ex_bubble", {31'd0, id_ex_bubble}, 32'd1);
      tick();
      apply(0, 0, 0, 0);
      chk("t2 next pc_write", {31'd0, pc_write}, 32'd1);
      chk("t2 stall_cycles", 32'(stall_cycles), 32'd1);
      tick();

      // T3: branch overrides load-use
      do_reset();
      apply(1, 1, 0, 0);
      chk("t3 pc_write", {31'd0, pc_write}, 32'd1);
      chk("t3 if_id_flush", {31'd0, if_id_flush}, 32'd1);
      chk("t3 id_ex_bubble", {31'd0, id_ex_bubble}, 32'd1);
      tick();
      apply(0, 0, 0, 0);
      chk("t3 flush_events", 32'(flush_events), 32'd1);
      chk("t3 stall_cycles", 32'(stall_cycles), 32'd0);
      tick();

      // T4: memory wait with a pending branch
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(0, 1, 1, 0);
         chk("t4 freeze pc_write", {31'd0, pc_write}, 32'd0);
         chk("t4 freeze flush", {31'd0, if_id_flush}, 32'd0);
         tick();
         chk("t4 state", {30'd0, state}, 32'd1);
      end
      apply(0, 1, 0, 0);
      chk("t4 release flush", {31'd0, if_id_flush}, 32'd1);
      chk("t4 release pc_write", {31'd0, pc_write}, 32'd1);
      tick();
      apply(0, 0, 0, 0);
      chk("t4 state run", {30'd0, state}, 32'd0);
      chk("t4 stall_cycles", 32'(stall_cycles), 32'd3);
      chk("t4 flush_events", 32'(flush_events), 32'd1);
      tick();

      // T5: watchdog timeout
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         apply(0, 0, 1, 0);
         tick();
         if (i == TIMEOUT - 1) begin
            chk("t5 pre state", {30'd0, state}, 32'd1);
            chk("t5 pre err", {31'd0, timeout_err}, 32'd0);
         end
         if (i == TIMEOUT) begin
            chk("t5 state err", {30'd0, state}, 32'd2);
            chk("t5 timeout_err", {31'd0, timeout_err}, 32'd1);
         end
      end
      for (int i = 0; i < 3; i++) begin
         apply(i[0], 1, 0, 0);
         chk("t5 err freeze", {31'd0, pc_write}, 32'd0);
         chk("t5 err state", {30'd0, state}, 32'd2);
         tick();
      end
      chk("t5 stall saturated", 32'(stall_cycles), 32'(CMAX));
      do_reset();
      apply(0, 0, 0, 0);
      chk("t5 after reset state", {30'd0, state}, 32'd0);
      chk("t5 after reset err", {31'd0, timeout_err}, 32'd0);
      tick();

      // T6: flush counter saturation and clear priority
      do_reset();
      for (int i = 0; i < CMAX + 2; i++) begin
         apply(0, 1, 0, 0);
         tick();
      end
      chk("t6 flush saturated", 32'(flush_events), 32'(CMAX));
      apply(0, 1, 0, 1);
      tick();
      chk("t6 clr wins", 32'(flush_events), 32'd0);
      apply(1, 0, 0, 1);
      tick();
      chk("t6 clr stall", 32'(stall_cycles), 32'd0);
      apply(0, 0, 0, 0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
